pipe_controller: RTL and testbench
==================================

Name: pipe_controller

Overview:
- Run/halt sequencer for the core pipeline; drives the control strobes consumed by the program counter and pipe registers: `state`, `progressPipe`, `stepPipe`, `stallPipe`.
- Turns management run/halt/single-step requests, breakpoints and memory handshakes into cycle-exact advance/stall decisions.
- Keeps the 64-bit cycle and instructions-retired counters for the core.

Parameters:
- RESET_RUN, 0: 1 = leave reset directly in RUN, 0 = leave reset in HALT.
- HALT_ON_EBREAK, 1: 1 = retiring EBREAK halts the core; 0 = EBREAK treated as normal instruction.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- management_run  in  1  pulse: start free-running execution
- management_halt  in  1  pulse: request halt
- management_step  in  1  pulse: execute exactly one instruction
- fetch_valid  in  1  instruction for fetchProgramCounter is available
- memory_busy  in  1  data load/store in flight; pipe must not advance
- pipe1_isEBREAK  in  1  instruction in execute stage is EBREAK
- state  out  1  0=HALT, 1=EXECUTE
- progressPipe  out  1  in-flight work still completing
- stepPipe  out  1  pipe advances this cycle
- stallPipe  out  1  bubble: PC does not take +4, execute PC not updated
- halted  out  1  fully idle in HALT (management writes accepted)
- stepDone  out  1  one-cycle pulse when a single-step completes
- cycleCount  out  64  clocks spent with state=1
- instretCount  out  64  instructions retired

Behaviour:
- Internal FSM states: HALT, RUN, STEP, DRAIN. Encodings live in the shared package.
- Reset: FSM = RUN if RESET_RUN else HALT; counters = 0; stepDone = 0.
- Outputs are combinational from the registered FSM state and inputs. Reset values with RESET_RUN=0: state=0, stepPipe=0, stallPipe=0, progressPipe=0, halted=1.
- state = 1 in RUN or STEP, else 0.
- stepPipe = state & !memory_busy.
- stallPipe = stepPipe & !fetch_valid.
- retire = stepPipe & !stallPipe.
- progressPipe = (FSM==DRAIN) | memory_busy.
- halted = (FSM==HALT) & !memory_busy.
- HALT transitions:
  - management_run → RUN.
  - else management_step → STEP.
  - Both accepted only when halted=1; otherwise ignored, no queuing.
- RUN transitions:
  - management_halt → DRAIN.
  - retire & pipe1_isEBREAK & HALT_ON_EBREAK → DRAIN.
- STEP transitions:
  - retire → DRAIN; stepDone pulses in the cycle after retire.
  - management_halt before retire → DRAIN, no stepDone.
- DRAIN: state=0, so no further stepPipe. Stay while memory_busy; → HALT on the first cycle memory_busy=0.
- Priority in one cycle: halt > EBREAK > step completion. management_run/step in RUN, STEP or DRAIN are ignored.
- Latency:
  - request pulse at edge N → FSM changes at N+1; first stepPipe possible in cycle N+1.
  - halt pulse at N → state=0 from N+1. The instruction stepping at N still completes.
- Counters:
  - cycleCount += 1 each cycle with state=1.
  - instretCount += 1 on retire.
  - Both wrap modulo 2^64 with no flag; a carry across bit 31 must be correct.
- Reset mid-operation (any FSM state, memory_busy high): next cycle is the reset state, counters 0, no stepDone.
- Inputs are sampled only on clk; no combinational path from management_* to stepPipe.

Decomposition:
- Shared package core_pipe_pkg:
  - FSM state localparams (HALT=2'd0, RUN=2'd1, STEP=2'd2, DRAIN=2'd3).
  - STATE_HALT/STATE_EXECUTE 1-bit constants, shared with the program counter.
- One sub-module: perf_counter64 (enable-gated 64-bit wrapping counter, synchronous clear), instantiated twice.

Test Plan:
- Reset with RESET_RUN=0, then management_run with fetch_valid=1 and memory_busy=0 for 10 cycles → state=1, stepPipe=1 every cycle, cycleCount=10, instretCount=10.
- From HALT, management_step with fetch_valid=0 for 3 cycles then 1 → stallPipe high for 3 cycles, a single retire, stepDone one pulse, instretCount=1, halted=1 afterwards.
- RUN with memory_busy held 4 cycles, halt pulsed in cycle 1 → stepPipe=0 throughout, FSM in DRAIN with progressPipe=1, HALT entered on the cycle memory_busy drops, halted=1.
- RUN with pipe1_isEBREAK=1 on a retiring instruction (HALT_ON_EBREAK=1) → state=0 on the next cycle; repeat with HALT_ON_EBREAK=0 → keeps running.
- Preload counters near 0xFFFFFFFF (force) and run 2 cycles → cycleCount upper word increments and lower word wraps to 0x1.
- Assert rst while in STEP with memory_busy=1 → next cycle HALT, counters 0, stepDone=0; management_step in DRAIN ignored.

Source files
------------

// File: rtl/core_pipe_pkg.sv
// rtl/core_pipe_pkg.sv - shared encodings for the core pipeline run/halt sequencer
//
// Contents:
//   FSM_HALT/FSM_RUN/FSM_STEP/FSM_DRAIN   sequencer FSM encodings (2 bits)
//   STATE_HALT/STATE_EXECUTE              1-bit architectural run state, shared with the PC
//   fsm_executes()                        1 when an FSM encoding lets the pipe execute
package core_pipe_pkg;

    localparam logic [1:0] FSM_HALT  = 2'd0;
    localparam logic [1:0] FSM_RUN   = 2'd1;
    localparam logic [1:0] FSM_STEP  = 2'd2;
    localparam logic [1:0] FSM_DRAIN = 2'd3;

    localparam logic STATE_HALT    = 1'b0;
    localparam logic STATE_EXECUTE = 1'b1;

    function automatic logic fsm_executes(input logic [1:0] fsm);
        return (fsm == FSM_RUN) || (fsm == FSM_STEP);
    endfunction

endpackage

// File: rtl/perf_counter64.sv
// rtl/perf_counter64.sv - enable-gated 64-bit wrapping counter with synchronous clear
//
// Ports:
//   clk         clock
//   clear       synchronous clear, highest priority
//   en          count enable, +1 per enabled clock, wraps modulo 2^64
//   load        synchronous load of load_value (below clear, above en)
//   load_value  value taken when load is high
//   count       current count
module perf_counter64 (
    input  logic        clk,
    input  logic        clear,
    input  logic        en,
    input  logic        load,
    input  logic [63:0] load_value,
    output logic [63:0] count
);

    // A single 64-bit add keeps the carry from the low word into the high
    // word in the same clock, so the count never shows a torn value.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - run/halt/single-step sequencer and cycle/instret counters for the core pipe
//
// Parameters:
//   RESET_RUN       1 = leave reset in RUN, 0 = leave reset in HALT
//   HALT_ON_EBREAK  1 = a retiring EBREAK halts the core
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   management_run/halt/step      one-cycle management request pulses
//   fetch_valid                   instruction at the fetch PC is available
//   memory_busy                   data access in flight, pipe must hold
//   pipe1_isEBREAK                execute-stage instruction is EBREAK
//   state                         0 = HALT, 1 = EXECUTE
//   progressPipe                  in-flight work still completing
//   stepPipe                      pipe advances this cycle
//   stallPipe                     bubble: PC and execute PC hold
//   halted                        fully idle, management writes accepted
//   stepDone                      one-cycle pulse after a single step retires
//   cycleCount, instretCount      64-bit executing-cycle and retired-instruction counts
module pipe_controller
    import core_pipe_pkg::*;
#(
    parameter int RESET_RUN      = 0,
    parameter int HALT_ON_EBREAK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        management_run,
    input  logic        management_halt,
    input  logic        management_step,
    input  logic        fetch_valid,
    input  logic        memory_busy,
    input  logic        pipe1_isEBREAK,
    output logic        state,
    output logic        progressPipe,
    output logic        stepPipe,
    output logic        stallPipe,
    output logic        halted,
    output logic        stepDone,
    output logic [63:0] cycleCount,
    output logic [63:0] instretCount
);

    localparam logic [1:0] FSM_RESET    = (RESET_RUN != 0) ? FSM_RUN : FSM_HALT;
    localparam logic       EBREAK_HALTS = (HALT_ON_EBREAK != 0);

    logic [1:0]  fsm;
    logic [1:0]  fsm_next;
    logic        retire;
    logic        ebreak_hit;
    logic        step_complete;
    logic        step_done_q;

    // Seed path into the cycle counter; tied off in the core so the count
    // only ever moves by clear or increment, but kept as a net so it can be
    // driven when the wrap behaviour needs to be exercised.
    logic        cycle_seed_en;
    logic [63:0] cycle_seed_value;

    assign cycle_seed_en    = 1'b0;
    assign cycle_seed_value = '0;

    // All strobes are decoded from the registered FSM plus the pipe-side
    // inputs only; management requests reach the strobes one clock later.
    assign state        = fsm_executes(fsm) ? STATE_EXECUTE : STATE_HALT;
    assign stepPipe     = state & ~memory_busy;
    assign stallPipe    = stepPipe & ~fetch_valid;
    assign retire       = stepPipe & ~stallPipe;
    assign progressPipe = (fsm == FSM_DRAIN) | memory_busy;
    assign halted       = (fsm == FSM_HALT) & ~memory_busy;
    assign stepDone     = step_done_q;

    assign ebreak_hit   = retire & pipe1_isEBREAK & EBREAK_HALTS;

    // A step only counts as completed when neither a halt nor an EBREAK
    // stop claims the same retire; those take priority and end silently.
    assign step_complete = (fsm == FSM_STEP) & retire & ~management_halt & ~ebreak_hit;

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            FSM_HALT: begin
                // Requests while a memory access is still draining are
                // dropped, not remembered.
                if (halted) begin
                    if (management_run) begin
                        fsm_next = FSM_RUN;
                    end else if (management_step) begin
                        fsm_next = FSM_STEP;
                    end
                end
            end
            FSM_RUN: begin
                if (management_halt || ebreak_hit) begin
                    fsm_next = FSM_DRAIN;
                end
            end
            FSM_STEP: begin
                if (management_halt || retire) begin
                    fsm_next = FSM_DRAIN;
                end
            end
            FSM_DRAIN: begin
                if (!memory_busy) begin
                    fsm_next = FSM_HALT;
                end
            end
            default: fsm_next = FSM_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= FSM_RESET;
            step_done_q <= 1'b0;
        end else begin
            fsm         <= fsm_next;
            step_done_q <= step_complete;
        end
    end

    perf_counter64 u_cycle_count (
        .clk        (clk),
        .clear      (rst),
        .en         (state),
        .load       (cycle_seed_en),
        .load_value (cycle_seed_value),
        .count      (cycleCount)
    );

    perf_counter64 u_instret_count (
        .clk        (clk),
        .clear      (rst),
        .en         (retire),
        .load       (1'b0),
        .load_value (64'd0),
        .count      (instretCount)
    );

endmodule

// File: tb/tb_pipe_controller.sv
// tb/tb_pipe_controller.sv - scoreboard bench for pipe_controller
module tb_pipe_controller;

    localparam int F_STATE   = 0;
    localparam int F_STEP    = 1;
    localparam int F_STALL   = 2;
    localparam int F_PROG    = 3;
    localparam int F_HALTED  = 4;
    localparam int F_CYC     = 5;
    localparam int F_INST    = 6;
    localparam int F_NESTATE = 7;

    logic        clk;
    logic        rst;
    logic        management_run;
    logic        management_halt;
    logic        management_step;
    logic        fetch_valid;
    logic        memory_busy;
    logic        pipe1_isEBREAK;

    logic        state, progressPipe, stepPipe, stallPipe, halted, stepDone;
    logic [63:0] cycleCount, instretCount;
    logic        ne_state, ne_progressPipe, ne_stepPipe, ne_stallPipe, ne_halted, ne_stepDone;
    logic [63:0] ne_cycleCount, ne_instretCount;

    pipe_controller #(.RESET_RUN(0), .HALT_ON_EBREAK(1)) dut (
        .clk(clk), .rst(rst),
        .management_run(management_run), .management_halt(management_halt),
        .management_step(management_step), .fetch_valid(fetch_valid),
        .memory_busy(memory_busy), .pipe1_isEBREAK(pipe1_isEBREAK),
        .state(state), .progressPipe(progressPipe), .stepPipe(stepPipe),
        .stallPipe(stallPipe), .halted(halted), .stepDone(stepDone),
        .cycleCount(cycleCount), .instretCount(instretCount)
    );

    pipe_controller #(.RESET_RUN(1), .HALT_ON_EBREAK(0)) dut_ne (
        .clk(clk), .rst(rst),
        .management_run(management_run), .management_halt(management_halt),
        .management_step(management_step), .fetch_valid(fetch_valid),
        .memory_busy(memory_busy), .pipe1_isEBREAK(pipe1_isEBREAK),
        .state(ne_state), .progressPipe(ne_progressPipe), .stepPipe(ne_stepPipe),
        .stallPipe(ne_stallPipe), .halted(ne_halted), .stepDone(ne_stepDone),
        .cycleCount(ne_cycleCount), .instretCount(ne_instretCount)
    );

    typedef struct {
        int          cyc;
        string       name;
        int          field;
        logic [63:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   sd_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t mon_e;
    logic [63:0] mon_act;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(input int field);
        case (field)
            F_STATE:   return {63'd0, state};
            F_STEP:    return {63'd0, stepPipe};
            F_STALL:   return {63'd0, stallPipe};
            F_PROG:    return {63'd0, progressPipe};
            F_HALTED:  return {63'd0, halted};
            F_CYC:     return cycleCount;
            F_INST:    return instretCount;
            F_NESTATE: return {63'd0, ne_state};
            default:   return 64'hDEAD;
        endcase
    endfunction

    // Monitor: compares queued expectations due this cycle, and matches each
    // stepDone pulse the DUT presents against the expected pulse queue.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e   = exp_q.pop_front();
            mon_act = actual(mon_e.field);
            n_cmp++;
            if (mon_e.cyc != cyc || mon_act !== mon_e.value) begin
                n_bad++;
                $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h (due cycle %0d)",
                         mon_e.name, cyc, mon_act, mon_e.value, mon_e.cyc);
            end
        end
        if (sd_q.size() > 0 && sd_q[0] < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stepDone_missing: no pulse, expected in cycle %0d", sd_q[0]);
            void'(sd_q.pop_front());
        end
        if (stepDone === 1'b1) begin
            n_cmp++;
            if (sd_q.size() == 0) begin
                n_bad++;
                $display("FAIL stepDone_unexpected: pulse in cycle %0d, expected none", cyc);
            end else if (sd_q[0] != cyc) begin
                n_bad++;
                $display("FAIL stepDone_timing: pulse in cycle %0d expected in cycle %0d", cyc, sd_q[0]);
                void'(sd_q.pop_front());
            end else begin
                void'(sd_q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input int field, input logic [63:0] value);
        exp_t e;
        e.cyc   = cyc;
        e.name  = name;
        e.field = field;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        management_run = 1'b0;
        management_halt = 1'b0;
        management_step = 1'b0;
        fetch_valid = 1'b1;
        memory_busy = 1'b0;
        pipe1_isEBREAK = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_state",    F_STATE,   0);
        chk("rst_step",     F_STEP,    0);
        chk("rst_stall",    F_STALL,   0);
        chk("rst_prog",     F_PROG,    0);
        chk("rst_halted",   F_HALTED,  1);
        chk("rst_cyc",      F_CYC,     0);
        chk("rst_inst",     F_INST,    0);
        chk("rst_run_inst", F_NESTATE, 1);

        // Free run for 10 cycles, halt pulsed in the last one
        management_run = 1'b1;
        tick();
        management_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("run_state", F_STATE, 1);
            chk("run_step",  F_STEP,  1);
            chk("run_stall", F_STALL, 0);
            chk("run_cyc",   F_CYC,   64'(i));
            chk("run_inst",  F_INST,  64'(i));
            if (i == 9) management_halt = 1'b1;
            tick();
            management_halt = 1'b0;
        end
        chk("run_drain_state", F_STATE, 0);
        chk("run_drain_prog",  F_PROG,  1);
        chk("run_cyc10",       F_CYC,   10);
        chk("run_inst10",      F_INST,  10);
        tick();
        chk("run_halted", F_HALTED, 1);

        // Single step with three fetch stalls
        management_step = 1'b1;
        tick();
        management_step = 1'b0;
        fetch_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("step_state", F_STATE, 1);
            chk("step_stall", F_STALL, 1);
            chk("step_inst",  F_INST,  10);
            tick();
        end
        fetch_valid = 1'b1;
        chk("step_retire_stall", F_STALL, 0);
        chk("step_retire_step",  F_STEP,  1);
        sd_q.push_back(cyc + 1);
        tick();
        chk("step_after_state", F_STATE, 0);
        chk("step_after_inst",  F_INST,  11);
        tick();
        chk("step_halted", F_HALTED, 1);
        chk("step_cyc",    F_CYC,    14);

        // Run, memory busy 4 cycles, halt in the first; step in DRAIN ignored
        management_run = 1'b1;
        tick();
        management_run = 1'b0;
        memory_busy = 1'b1;
        management_halt = 1'b1;
        chk("busy_state1",  F_STATE,  1);
        chk("busy_step1",   F_STEP,   0);
        chk("busy_prog1",   F_PROG,   1);
        tick();
        management_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            management_step = (i == 1);
            chk("busy_state",  F_STATE,  0);
            chk("busy_step",   F_STEP,   0);
            chk("busy_prog",   F_PROG,   1);
            chk("busy_halted", F_HALTED, 0);
            tick();
        end
        management_step = 1'b0;
        memory_busy = 1'b0;
        chk("drain_prog",   F_PROG,   1);
        chk("drain_halted", F_HALTED, 0);
        tick();
        chk("drained_halted", F_HALTED, 1);
        chk("drained_prog",   F_PROG,   0);
        chk("drained_cyc",    F_CYC,    15);
        tick();
        // Run request while a memory access is still in flight is dropped
        memory_busy = 1'b1;
        management_run = 1'b1;
        chk("busyhalt_halted", F_HALTED, 0);
        chk("busyhalt_prog",   F_PROG,   1);
        tick();
        memory_busy = 1'b0;
        management_run = 1'b0;
        chk("busyhalt_state",  F_STATE,  0);
        chk("busyhalt_halted2", F_HALTED, 1);
        tick();

        // EBREAK: stalled EBREAK does not halt, retiring one does
        management_run = 1'b1;
        tick();
        management_run = 1'b0;
        pipe1_isEBREAK = 1'b1;
        fetch_valid = 1'b0;
        chk("ebk_stall_state", F_STATE, 1);
        tick();
        fetch_valid = 1'b1;
        chk("ebk_stall_kept", F_STATE, 1);
        tick();
        pipe1_isEBREAK = 1'b0;
        chk("ebk_halt_state", F_STATE,   0);
        chk("ebk_ne_running", F_NESTATE, 1);
        chk("ebk_inst",       F_INST,    12);
        chk("ebk_cyc",        F_CYC,     17);
        management_halt = 1'b1;
        tick();
        management_halt = 1'b0;
        chk("ebk_halted",    F_HALTED,  1);
        chk("ebk_ne_halted", F_NESTATE, 0);
        tick();

        // Seed the cycle counter just below the 32-bit boundary and run 2 cycles
        force dut.cycle_seed_en = 1'b1;
        force dut.cycle_seed_value = 64'h0000_0000_FFFF_FFFF;
        tick();
        release dut.cycle_seed_en;
        release dut.cycle_seed_value;
        chk("seed_cyc", F_CYC, 64'h0000_0000_FFFF_FFFF);
        management_run = 1'b1;
        tick();
        management_run = 1'b0;
        chk("wrap_cyc0", F_CYC, 64'h0000_0000_FFFF_FFFF);
        tick();
        management_halt = 1'b1;
        chk("wrap_cyc1", F_CYC, 64'h0000_0001_0000_0000);
        tick();
        management_halt = 1'b0;
        chk("wrap_cyc2",  F_CYC,   64'h0000_0001_0000_0001);
        chk("wrap_state", F_STATE, 0);
        chk("wrap_inst",  F_INST,  14);
        tick();

        // Reset while stepping with memory busy
        management_step = 1'b1;
        tick();
        management_step = 1'b0;
        memory_busy = 1'b1;
        rst = 1'b1;
        chk("rststep_state", F_STATE, 1);
        chk("rststep_step",  F_STEP,  0);
        tick();
        rst = 1'b0;
        chk("rststep_after_state",  F_STATE,   0);
        chk("rststep_after_halted", F_HALTED,  0);
        chk("rststep_after_cyc",    F_CYC,     0);
        chk("rststep_after_inst",   F_INST,    0);
        chk("rststep_ne_state",     F_NESTATE, 1);
        tick();
        memory_busy = 1'b0;
        chk("rststep_halted", F_HALTED, 1);
        tick();
        tick();
        #5;

        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked, expected 0x%0h", mon_e.name, mon_e.value);
        end
        while (sd_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stepDone_missing: no pulse, expected in cycle %0d", sd_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
